// File: rtl/gemm_operand_feeder_if.sv
// Handshake and data bundle between the GEMM operand feeder and its surroundings.
// Latency: none, wires only.
// Backpressure: start_valid/start_ready on the request side, out_valid/out_ready on the result side.
interface gemm_operand_feeder_if #(
    parameter int DATA_WIDTH   = 8,
    parameter int PE_OUT_WIDTH = 8,
    parameter int ARRAY_N      = 16,
    parameter int ADDR_WIDTH   = 10
);
    localparam int MEM_DATA_WIDTH = DATA_WIDTH * ARRAY_N;

    logic                      start_valid;
    logic                      start_ready;
    logic [ADDR_WIDTH-1:0]     start_base;
    logic                      busy;
    logic                      mem_rd_en;
    logic [ADDR_WIDTH-1:0]     mem_rd_addr;
    logic [MEM_DATA_WIDTH-1:0] mem_inp_rdata;
    logic [MEM_DATA_WIDTH-1:0] mem_wgt1_rdata;
    logic [MEM_DATA_WIDTH-1:0] mem_wgt2_rdata;
    logic [MEM_DATA_WIDTH-1:0] inp;
    logic [MEM_DATA_WIDTH-1:0] wgt1;
    logic [MEM_DATA_WIDTH-1:0] wgt2;
    logic [PE_OUT_WIDTH-1:0]   acc1;
    logic [PE_OUT_WIDTH-1:0]   acc2;
    logic [PE_OUT_WIDTH-1:0]   gemm_result1;
    logic [PE_OUT_WIDTH-1:0]   gemm_result2;
    logic                      out_valid;
    logic                      out_ready;
    logic [PE_OUT_WIDTH-1:0]   out_result1;
    logic [PE_OUT_WIDTH-1:0]   out_result2;

    modport master (
        input  start_valid, start_base, mem_inp_rdata, mem_wgt1_rdata, mem_wgt2_rdata,
        input  gemm_result1, gemm_result2, out_ready,
        output start_ready, busy, mem_rd_en, mem_rd_addr, inp, wgt1, wgt2, acc1, acc2,
        output out_valid, out_result1, out_result2
    );

    modport slave (
        output start_valid, start_base, mem_inp_rdata, mem_wgt1_rdata, mem_wgt2_rdata,
        output gemm_result1, gemm_result2, out_ready,
        input  start_ready, busy, mem_rd_en, mem_rd_addr, inp, wgt1, wgt2, acc1, acc2,
        input  out_valid, out_result1, out_result2
    );
endinterface

// File: rtl/gemm_operand_feeder.sv
// Walks one tile's channel dimension in ARRAY_N-wide beats, feeding GEMM and folding results into acc1/acc2.
// Latency: 2+GEMM_LATENCY cycles per beat; out_valid 1+BEATS*(2+GEMM_LATENCY) cycles after start accept.
// Backpressure: results held in DONE until out_ready; new starts only in IDLE. Optional GEMM_OPERAND_FEEDER_BIAS_EN adds bias1/bias2.
module gemm_operand_feeder #(
    parameter int DATA_WIDTH     = 8,
    parameter int PE_OUT_WIDTH   = 8,
    parameter int ARRAY_N        = 16,
    parameter int CHANNEL        = 96,
    parameter int MEM_DATA_WIDTH = DATA_WIDTH * ARRAY_N,
    parameter int ADDR_WIDTH     = 10,
    parameter int GEMM_LATENCY   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
`ifdef GEMM_OPERAND_FEEDER_BIAS_EN
    input  logic [PE_OUT_WIDTH-1:0] bias1,
    input  logic [PE_OUT_WIDTH-1:0] bias2,
`endif
    gemm_operand_feeder_if.master   bus
);
    localparam int BEATS = CHANNEL / ARRAY_N;
    localparam int K_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int W_W   = (GEMM_LATENCY > 1) ? $clog2(GEMM_LATENCY) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(BEATS - 1);
    localparam logic [W_W-1:0] W_LAST = W_W'(GEMM_LATENCY - 1);

    typedef enum logic [2:0] {IDLE, READ, LOAD, WAIT, DONE} state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   base;
    logic [K_W-1:0]          k;
    logic [W_W-1:0]          w;
    logic [PE_OUT_WIDTH-1:0] acc1_init, acc2_init;

`ifdef GEMM_OPERAND_FEEDER_BIAS_EN
    assign acc1_init = bias1;
    assign acc2_init = bias2;
`else
    assign acc1_init = '0;
    assign acc2_init = '0;
`endif

    // Address is the tile base plus beat index; ADDR_WIDTH truncation gives the modular wrap.
    assign bus.mem_rd_addr = base + ADDR_WIDTH'(k);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        state_nxt       = state;
        bus.start_ready = 1'b0;
        bus.busy        = 1'b1;
        bus.mem_rd_en   = 1'b0;
        bus.out_valid   = 1'b0;
        bus.out_result1 = '0;
        bus.out_result2 = '0;
        case (state)
            IDLE: begin
                bus.start_ready = 1'b1;
                bus.busy        = 1'b0;
                if (bus.start_valid) state_nxt = READ;
            end
            READ: begin
                bus.mem_rd_en = 1'b1;
                state_nxt     = LOAD;
            end
            LOAD: state_nxt = WAIT;
            WAIT: begin
                if (w == W_LAST) state_nxt = (k == K_LAST) ? DONE : READ;
            end
            DONE: begin
                bus.out_valid   = 1'b1;
                bus.out_result1 = bus.acc1;
                bus.out_result2 = bus.acc2;
                // A start in this same cycle is not seen: start_ready is low until IDLE.
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: tile base, beat/wait counters, operand registers and partial sums.
    always_ff @(posedge clk) begin
        if (rst) begin
            base     <= '0;
            k        <= '0;
            w        <= '0;
            bus.inp  <= MEM_DATA_WIDTH'(0);
            bus.wgt1 <= MEM_DATA_WIDTH'(0);
            bus.wgt2 <= MEM_DATA_WIDTH'(0);
            bus.acc1 <= PE_OUT_WIDTH'(0);
            bus.acc2 <= PE_OUT_WIDTH'(0);
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start_valid) begin
                        base     <= bus.start_base;
                        k        <= '0;
                        bus.acc1 <= acc1_init;
                        bus.acc2 <= acc2_init;
                    end
                end
                LOAD: begin
                    bus.inp  <= bus.mem_inp_rdata;
                    bus.wgt1 <= bus.mem_wgt1_rdata;
                    bus.wgt2 <= bus.mem_wgt2_rdata;
                    w        <= '0;
                end
                WAIT: begin
                    if (w == W_LAST) begin
                        bus.acc1 <= bus.gemm_result1;
                        bus.acc2 <= bus.gemm_result2;
                        if (k != K_LAST) k <= k + 1'b1;
                    end else begin
                        w <= w + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gemm_operand_feeder.sv
module tb_gemm_operand_feeder;
    localparam int DW = 8;
    localparam int PW = 8;
    localparam int AN = 16;
    localparam int MW = DW * AN;
    localparam int AW = 10;
    localparam int CH = 96;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]    v_inp, v_w1, v_w2;
    logic [AW-1:0] rd_addr [8];
    int            rd_cyc [8];

    gemm_operand_feeder_if #(.DATA_WIDTH(DW), .PE_OUT_WIDTH(PW), .ARRAY_N(AN), .ADDR_WIDTH(AW)) b1 ();
    gemm_operand_feeder_if #(.DATA_WIDTH(DW), .PE_OUT_WIDTH(PW), .ARRAY_N(AN), .ADDR_WIDTH(AW)) b3 ();

`ifdef GEMM_OPERAND_FEEDER_BIAS_EN
    logic [PW-1:0] bias1, bias2;
`endif

    gemm_operand_feeder #(
        .DATA_WIDTH(DW), .PE_OUT_WIDTH(PW), .ARRAY_N(AN), .CHANNEL(CH),
        .MEM_DATA_WIDTH(MW), .ADDR_WIDTH(AW), .GEMM_LATENCY(1)
    ) u_l1 (
        .clk(clk), .rst(rst),
`ifdef GEMM_OPERAND_FEEDER_BIAS_EN
        .bias1(bias1), .bias2(bias2),
`endif
        .bus(b1)
    );

    gemm_operand_feeder #(
        .DATA_WIDTH(DW), .PE_OUT_WIDTH(PW), .ARRAY_N(AN), .CHANNEL(CH),
        .MEM_DATA_WIDTH(MW), .ADDR_WIDTH(AW), .GEMM_LATENCY(3)
    ) u_l3 (
        .clk(clk), .rst(rst),
`ifdef GEMM_OPERAND_FEEDER_BIAS_EN
        .bias1(bias1), .bias2(bias2),
`endif
        .bus(b3)
    );

    // Memory model: every lane of a word carries the same test value; data valid only the cycle after a read.
    always @(posedge clk) begin
        b1.mem_inp_rdata  <= b1.mem_rd_en ? {AN{v_inp}} : '0;
        b1.mem_wgt1_rdata <= b1.mem_rd_en ? {AN{v_w1}}  : '0;
        b1.mem_wgt2_rdata <= b1.mem_rd_en ? {AN{v_w2}}  : '0;
        b3.mem_inp_rdata  <= b3.mem_rd_en ? {AN{v_inp}} : '0;
        b3.mem_wgt1_rdata <= b3.mem_rd_en ? {AN{v_w1}}  : '0;
        b3.mem_wgt2_rdata <= b3.mem_rd_en ? {AN{v_w2}}  : '0;
    end

    function automatic logic [PW-1:0] dot(input logic [MW-1:0] a, input logic [MW-1:0] b);
        logic [PW-1:0] s;
        s = '0;
        for (int i = 0; i < AN; i++) s = s + PW'(a[i*DW +: DW] * b[i*DW +: DW]);
        return s;
    endfunction

    // GEMM model, latency 1: result follows stable operands within the first WAIT cycle.
    assign b1.gemm_result1 = b1.acc1 + dot(b1.inp, b1.wgt1);
    assign b1.gemm_result2 = b1.acc2 + dot(b1.inp, b1.wgt2);

    // GEMM model, latency 3: two extra pipeline stages after the combinational sum.
    logic [PW-1:0] p1a, p1b, p2a, p2b;
    always @(posedge clk) begin
        p1a <= b3.acc1 + dot(b3.inp, b3.wgt1);
        p2a <= b3.acc2 + dot(b3.inp, b3.wgt2);
        p1b <= p1a;
        p2b <= p2a;
    end
    assign b3.gemm_result1 = p1b;
    assign b3.gemm_result2 = p2b;

    // Starts a tile on the L=1 instance and runs until out_valid (left pending with out_ready low).
    task automatic run_tile1(input logic [AW-1:0] base, output int t_valid, output int n_rd, output int n_bad);
        @(negedge clk);
        b1.start_base  = base;
        b1.start_valid = 1'b1;
        b1.out_ready   = 1'b0;
        t_valid = -1;
        n_rd    = 0;
        n_bad   = 0;
        for (int c = 1; c <= 60 && t_valid < 0; c++) begin
            @(negedge clk);
            b1.start_valid = 1'b0;
            if (b1.mem_rd_en) begin
                if (n_rd < 8) begin
                    rd_addr[n_rd] = b1.mem_rd_addr;
                    rd_cyc[n_rd]  = c;
                end
                n_rd++;
            end
            if (b1.out_valid) t_valid = c;
            else if (b1.start_ready || !b1.busy) n_bad++;
        end
    endtask

    task automatic handshake1;
        b1.out_ready = 1'b1;
        @(negedge clk);
        b1.out_ready = 1'b0;
        n_vec++;
        if (b1.out_valid !== 1'b0 || b1.start_ready !== 1'b1) begin
            n_err++;
            $display("FAIL handshake: out_valid=%b start_ready=%b, need 0/1", b1.out_valid, b1.start_ready);
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        n_vec++;
        if ({b1.start_ready, b1.busy, b1.mem_rd_en, b1.out_valid} !== 4'b1000) begin
            n_err++;
            $display("FAIL reset_ctl: rdy/busy/rd/ov=%b, need 1000",
                     {b1.start_ready, b1.busy, b1.mem_rd_en, b1.out_valid});
        end
        n_vec++;
        if (b1.mem_rd_addr !== '0) begin
            n_err++;
            $display("FAIL reset_addr: got %h, need 000", b1.mem_rd_addr);
        end
        n_vec++;
        if ({b1.inp, b1.wgt1, b1.wgt2} !== '0) begin
            n_err++;
            $display("FAIL reset_operands: nonzero operand registers");
        end
        n_vec++;
        if ({b1.acc1, b1.acc2, b1.out_result1, b1.out_result2} !== 32'h0) begin
            n_err++;
            $display("FAIL reset_acc: acc/result=%h, need 0",
                     {b1.acc1, b1.acc2, b1.out_result1, b1.out_result2});
        end
    endtask

    task automatic test_basic;
        int tv, nr, nb;
        v_inp = 8'd1; v_w1 = 8'd1; v_w2 = 8'd2;
        run_tile1(10'h010, tv, nr, nb);
        n_vec++;
        if (tv !== 19) begin n_err++; $display("FAIL basic_latency: out_valid at cycle %0d, need 19", tv); end
        n_vec++;
        if (nr !== 6) begin n_err++; $display("FAIL basic_reads: %0d reads, need 6", nr); end
        for (int j = 0; j < 6; j++) begin
            n_vec++;
            if (rd_addr[j] !== AW'(10'h010 + j) || rd_cyc[j] !== 1 + 3 * j) begin
                n_err++;
                $display("FAIL basic_read%0d: addr %h cyc %0d, need %h cyc %0d",
                         j, rd_addr[j], rd_cyc[j], AW'(10'h010 + j), 1 + 3 * j);
            end
        end
        n_vec++;
        if (nb !== 0) begin n_err++; $display("FAIL basic_busy: %0d cycles not busy, need 0", nb); end
        n_vec++;
        if (b1.out_result1 !== 8'd96 || b1.out_result2 !== 8'd192) begin
            n_err++;
            $display("FAIL basic_result: %0d/%0d, need 96/192", b1.out_result1, b1.out_result2);
        end
        handshake1();
    endtask

    task automatic test_wrap;
        int tv, nr, nb;
        v_inp = 8'd1; v_w1 = 8'd1; v_w2 = 8'd3;
        run_tile1(10'h020, tv, nr, nb);
        n_vec++;
        if (tv !== 19 || b1.out_result1 !== 8'd96 || b1.out_result2 !== 8'd32) begin
            n_err++;
            $display("FAIL wrap_result: cyc %0d %0d/%0d, need 19 96/32", tv, b1.out_result1, b1.out_result2);
        end
        handshake1();
    endtask

    task automatic test_hold_and_abort;
        int tv, nr, nb;
        v_inp = 8'd2; v_w1 = 8'd1; v_w2 = 8'd1;
        run_tile1(10'h000, tv, nr, nb);
        b1.start_base = 10'h040;
        for (int i = 0; i < 5; i++) begin
            b1.start_valid = 1'b1;
            @(negedge clk);
            n_vec++;
            if (b1.out_valid !== 1'b1 || b1.start_ready !== 1'b0 ||
                b1.out_result1 !== 8'd192 || b1.out_result2 !== 8'd192) begin
                n_err++;
                $display("FAIL hold%0d: ov=%b rdy=%b res=%0d/%0d, need 1 0 192/192",
                         i, b1.out_valid, b1.start_ready, b1.out_result1, b1.out_result2);
            end
        end
        b1.out_ready = 1'b1;
        @(negedge clk);
        b1.out_ready = 1'b0;
        n_vec++;
        if (b1.out_valid !== 1'b0 || b1.busy !== 1'b0 || b1.start_ready !== 1'b1) begin
            n_err++;
            $display("FAIL hold_release: ov=%b busy=%b rdy=%b, need 0 0 1", b1.out_valid, b1.busy, b1.start_ready);
        end
        // start_valid still high: this cycle is cycle 0 of the next tile.
        @(negedge clk);
        b1.start_valid = 1'b0;
        n_vec++;
        if (b1.busy !== 1'b1 || b1.mem_rd_en !== 1'b1 || b1.mem_rd_addr !== 10'h040) begin
            n_err++;
            $display("FAIL next_start: busy=%b rd=%b addr=%h, need 1 1 040", b1.busy, b1.mem_rd_en, b1.mem_rd_addr);
        end
        for (int c = 2; c <= 12; c++) @(negedge clk);
        // Cycle 12 is the WAIT cycle of beat 3.
        n_vec++;
        if (b1.busy !== 1'b1 || b1.mem_rd_en !== 1'b0) begin
            n_err++;
            $display("FAIL beat3_wait: busy=%b rd=%b, need 1 0", b1.busy, b1.mem_rd_en);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_vec++;
        if ({b1.start_ready, b1.busy, b1.mem_rd_en, b1.out_valid} !== 4'b1000 || b1.mem_rd_addr !== '0 ||
            {b1.inp, b1.wgt1, b1.wgt2} !== '0 || {b1.acc1, b1.acc2, b1.out_result1, b1.out_result2} !== 32'h0) begin
            n_err++;
            $display("FAIL abort_reset: ctl=%b addr=%h acc=%h, need 1000 000 0",
                     {b1.start_ready, b1.busy, b1.mem_rd_en, b1.out_valid}, b1.mem_rd_addr, {b1.acc1, b1.acc2});
        end
        v_inp = 8'd1; v_w1 = 8'd2; v_w2 = 8'd1;
        run_tile1(10'h100, tv, nr, nb);
        n_vec++;
        if (tv !== 19 || nr !== 6 || b1.out_result1 !== 8'd192 || b1.out_result2 !== 8'd96) begin
            n_err++;
            $display("FAIL after_abort: cyc %0d reads %0d res %0d/%0d, need 19 6 192/96",
                     tv, nr, b1.out_result1, b1.out_result2);
        end
        handshake1();
    endtask

    task automatic test_latency3;
        int tv, nr;
        v_inp = 8'd1; v_w1 = 8'd1; v_w2 = 8'd2;
        @(negedge clk);
        b3.start_base  = 10'h3FE;
        b3.start_valid = 1'b1;
        tv = -1;
        nr = 0;
        for (int c = 1; c <= 80 && tv < 0; c++) begin
            @(negedge clk);
            b3.start_valid = 1'b0;
            if (b3.mem_rd_en) begin
                if (nr < 8) begin
                    rd_addr[nr] = b3.mem_rd_addr;
                    rd_cyc[nr]  = c;
                end
                nr++;
            end
            if (b3.out_valid) tv = c;
        end
        n_vec++;
        if (tv !== 31 || nr !== 6) begin
            n_err++;
            $display("FAIL l3_timing: out_valid cyc %0d reads %0d, need 31 6", tv, nr);
        end
        for (int j = 0; j < 6; j++) begin
            n_vec++;
            if (rd_addr[j] !== AW'(10'h3FE + j) || rd_cyc[j] !== 1 + 5 * j) begin
                n_err++;
                $display("FAIL l3_read%0d: addr %h cyc %0d, need %h cyc %0d",
                         j, rd_addr[j], rd_cyc[j], AW'(10'h3FE + j), 1 + 5 * j);
            end
        end
        n_vec++;
        if (b3.out_result1 !== 8'd96 || b3.out_result2 !== 8'd192) begin
            n_err++;
            $display("FAIL l3_result: %0d/%0d, need 96/192", b3.out_result1, b3.out_result2);
        end
        b3.out_ready = 1'b1;
        @(negedge clk);
        b3.out_ready = 1'b0;
    endtask

`ifdef GEMM_OPERAND_FEEDER_BIAS_EN
    task automatic test_bias;
        int tv, nr, nb;
        bias1 = 8'd10; bias2 = 8'd250;
        v_inp = 8'd1; v_w1 = 8'd1; v_w2 = 8'd2;
        run_tile1(10'h010, tv, nr, nb);
        n_vec++;
        if (b1.out_result1 !== 8'd106 || b1.out_result2 !== 8'd186) begin
            n_err++;
            $display("FAIL bias_result: %0d/%0d, need 106/186", b1.out_result1, b1.out_result2);
        end
        handshake1();
    endtask
`endif

    initial begin
        rst = 1'b1;
        v_inp = '0; v_w1 = '0; v_w2 = '0;
        b1.start_valid = 1'b0; b1.start_base = '0; b1.out_ready = 1'b0;
        b3.start_valid = 1'b0; b3.start_base = '0; b3.out_ready = 1'b0;
`ifdef GEMM_OPERAND_FEEDER_BIAS_EN
        bias1 = '0; bias2 = '0;
`endif
        repeat (3) @(posedge clk);
        test_reset();
        rst = 1'b0;
        test_basic();
        test_wrap();
        test_hold_and_abort();
        test_latency3();
`ifdef GEMM_OPERAND_FEEDER_BIAS_EN
        test_bias();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/gemm_operand_feeder.md
# gemm_operand_feeder

Sequencer on the driving side of the GEMM array. It walks one output tile's CHANNEL dimension in ARRAY_N-wide beats, fetching activation and weight vectors from on-chip memory, presenting them with the running partial sums (acc1/acc2) to GEMM, and folding each returned gemm_result back into those partial sums. After the last beat it hands the two finished column results downstream on a valid/ready port.

## Interface
- DATA_WIDTH, 8, operand element width
- PE_OUT_WIDTH, 8, partial-sum/result width
- ARRAY_N, 16, PE rows; lanes per beat
- CHANNEL, 96, reduction length; must be a multiple of ARRAY_N; BEATS = CHANNEL/ARRAY_N (6)
- MEM_DATA_WIDTH, DATA_WIDTH*ARRAY_N, memory/GEMM operand bus width
- ADDR_WIDTH, 10, memory word address width
- GEMM_LATENCY, 1, cycles from stable operands to valid gemm_result (>=1)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start_valid  in  1  tile request
- start_ready  out  1  high only in IDLE
- start_base  in  ADDR_WIDTH  first memory word of the tile
- busy  out  1  high in any state except IDLE
- mem_rd_en  out  1  memory read strobe
- mem_rd_addr  out  ADDR_WIDTH  read address
- mem_inp_rdata / mem_wgt1_rdata / mem_wgt2_rdata  in  MEM_DATA_WIDTH each  read data, valid the cycle after mem_rd_en
- inp / wgt1 / wgt2  out  MEM_DATA_WIDTH each  registered operands to GEMM
- acc1 / acc2  out  PE_OUT_WIDTH each  registered partial sums to GEMM
- gemm_result1 / gemm_result2  in  PE_OUT_WIDTH each  GEMM outputs
- out_valid  in/out: out  1  final results valid
- out_ready  in  1  downstream accept
- out_result1 / out_result2  out  PE_OUT_WIDTH each  finished column sums

## Operation
- States: IDLE, READ, LOAD, WAIT, DONE. Beat counter k (0..BEATS-1), wait counter w (0..GEMM_LATENCY-1).
- IDLE: start_valid&&start_ready latches start_base, clears k, clears acc1/acc2 -> READ.
- READ: mem_rd_en=1, mem_rd_addr=(base+k) mod 2^ADDR_WIDTH -> LOAD.
- LOAD: register rdata into inp/wgt1/wgt2; clear w -> WAIT.
- WAIT: operands/acc held stable; on w==GEMM_LATENCY-1: acc1<=gemm_result1, acc2<=gemm_result2; if k==BEATS-1 -> DONE else k++ -> READ.
- DONE: out_valid=1, out_result = acc1/acc2; hold until out_ready, then -> IDLE.
- Arithmetic is GEMM's; feeder stores results unmodified, wraps modulo 2^PE_OUT_WIDTH.
- start_valid outside IDLE ignored (start_ready=0). In DONE, out_ready and start_valid same cycle: no start accepted; accepted earliest next cycle.
- rst at any point: -> IDLE, aborts tile, no out_valid for it.

## Timing
- Reset values: start_ready=1, busy=0, mem_rd_en=0, mem_rd_addr=0, inp/wgt1/wgt2=0, acc1/acc2=0, out_valid=0, out_result1/2=0.
- Per beat: 2+GEMM_LATENCY cycles. Start accepted at cycle 0 -> first READ cycle 1 -> out_valid at cycle 1+BEATS*(2+GEMM_LATENCY) (19 for defaults).
- mem_rd_en asserted exactly one cycle per beat, BEATS per tile.
- out_valid/out_result stable while out_valid&&!out_ready.
- Back-to-back: next tile accepted no earlier than cycle after DONE handshake.

## Configuration
- GEMM_OPERAND_FEEDER_BIAS_EN defined: extra inputs bias1/bias2 (PE_OUT_WIDTH), latched on start accept; acc1/acc2 initialise to them.
- Undefined: no bias ports; acc1/acc2 initialise to 0.

## Test plan
- GEMM behavioural model (L=1), all inp lanes=1, wgt1 lanes=1, wgt2 lanes=2, base=0x010 -> reads 0x010..0x015, out_valid at cycle 19, results 96/192.
- wgt2 lanes=3 -> result2 = 288 mod 256 = 32 (wrap).
- out_ready low 5 cycles in DONE -> out_valid and results held constant; start_valid meanwhile ignored; accepted cycle after handshake.
- rst asserted in WAIT of beat 3 -> next cycle all outputs at reset values; new start runs full 6 beats with fresh zero acc.
- GEMM_LATENCY=3 -> 5 cycles/beat, out_valid at cycle 31; base=0x3FE wraps addresses to 0x000..0x003.
- With BIAS_EN, bias1=10, bias2=250 on case 1 -> results 106/186.
